// File: rtl/pc_unit_if.sv
// Fetch-PC bus: control inputs from hazard/branch logic, PC state back out.
interface pc_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              w_ena;
  logic              stall;
  logic              exc_req;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus;
  logic              redir_pending;
  logic [ADDR_W-1:0] epc_out;
  logic              addr_err;

  modport master (
    output w_ena, stall, exc_req, redir_valid, redir_pc,
    input  pc_out, pc_plus, redir_pending, epc_out, addr_err
  );

  modport slave (
    input  w_ena, stall, exc_req, redir_valid, redir_pc,
    output pc_out, pc_plus, redir_pending, epc_out, addr_err
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised exception/redirect handling
// and a one-entry slot that holds a redirect arriving during a stall.
module pc_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(32'h0040_0000),
  parameter logic [ADDR_W-1:0]    EXC_VEC  = ADDR_W'(32'h0040_0004),
  parameter int unsigned          INC      = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_unit_if.slave bus
);
  localparam int unsigned LSB_W = $clog2(INC);

  typedef enum logic {RUN, PEND} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic [ADDR_W-1:0] epc, epc_d;
  logic [ADDR_W-1:0] pend_pc, pend_d;
  logic              addr_err, addr_err_d;

  logic              adv;
  logic [ADDR_W-1:0] aligned;
  logic              misaligned;

  assign adv        = bus.w_ena & ~bus.stall;
  assign aligned    = {bus.redir_pc[ADDR_W-1:LSB_W], LSB_W'(0)};
  assign misaligned = |bus.redir_pc[LSB_W-1:0];

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      epc      <= '0;
      pend_pc  <= '0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      epc      <= epc_d;
      pend_pc  <= pend_d;
      addr_err <= addr_err_d;
    end
  end

  // First matching rule wins; w_ena low freezes everything.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    epc_d      = epc;
    pend_d     = pend_pc;
    addr_err_d = 1'b0;
    if (bus.exc_req && bus.w_ena) begin
      pc_d    = EXC_VEC;
      epc_d   = pc;
      state_d = RUN;
    end else if (bus.redir_valid && adv) begin
      pc_d       = aligned;
      state_d    = RUN;
      addr_err_d = misaligned;
    end else if (bus.redir_valid && bus.stall && bus.w_ena) begin
      pend_d     = aligned;
      state_d    = PEND;
      addr_err_d = misaligned;
    end else if (state == PEND && adv) begin
      pc_d    = pend_pc;
      state_d = RUN;
    end else if (adv) begin
      pc_d = pc + ADDR_W'(INC);
    end
  end

  assign bus.pc_out        = pc;
  assign bus.pc_plus       = pc + ADDR_W'(INC);
  assign bus.redir_pending = (state == PEND);
  assign bus.epc_out       = epc;
  assign bus.addr_err      = addr_err;
endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pc_unit_if #(.ADDR_W(32)) bus ();

  pc_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0040_0000),
    .EXC_VEC (32'h0040_0004),
    .INC     (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic s, input logic e,
                       input logic rv, input logic [31:0] rp);
    bus.w_ena       = w;
    bus.stall       = s;
    bus.exc_req     = e;
    bus.redir_valid = rv;
    bus.redir_pc    = rp;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    #12;
    checks++;
    if (bus.pc_out !== 32'h0040_0000) begin
      failures++; $display("FAIL reset_pc got=%h exp=%h", bus.pc_out, 32'h0040_0000);
    end
    checks++;
    if (bus.epc_out !== 32'h0 || bus.redir_pending !== 1'b0 || bus.addr_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got epc=%h pend=%b err=%b exp 0/0/0",
               bus.epc_out, bus.redir_pending, bus.addr_err);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'h0040_0000;
    checks++;
    if (bus.pc_plus !== 32'h0040_0004) begin
      failures++; $display("FAIL seq_plus0 got=%h exp=%h", bus.pc_plus, 32'h0040_0004);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_pc = 32'h0040_0000 + 32'(4 * i);
      checks++;
      if (bus.pc_out !== exp_pc || bus.pc_plus !== exp_pc + 32'd4) begin
        failures++;
        $display("FAIL seq_pc%0d got=%h/%h exp=%h/%h", i, bus.pc_out, bus.pc_plus,
                 exp_pc, exp_pc + 32'd4);
      end
    end
  endtask

  task automatic test_stall_redirect();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0100);
    step();
    checks++;
    if (bus.pc_out !== 32'h0040_0010 || bus.redir_pending !== 1'b1) begin
      failures++;
      $display("FAIL stall_buf got pc=%h pend=%b exp pc=%h pend=1", bus.pc_out,
               bus.redir_pending, 32'h0040_0010);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (bus.pc_out !== 32'h0040_0010 || bus.redir_pending !== 1'b1) begin
      failures++;
      $display("FAIL stall_hold got pc=%h pend=%b exp pc=%h pend=1", bus.pc_out,
               bus.redir_pending, 32'h0040_0010);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (bus.pc_out !== 32'h0040_0100 || bus.redir_pending !== 1'b0) begin
      failures++;
      $display("FAIL stall_apply got pc=%h pend=%b exp pc=%h pend=0", bus.pc_out,
               bus.redir_pending, 32'h0040_0100);
    end
  endtask

  task automatic test_overwrite();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0100);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0200);
    step();
    checks++;
    if (bus.pc_out !== 32'h0040_0100 || bus.redir_pending !== 1'b1) begin
      failures++;
      $display("FAIL ovw_buf got pc=%h pend=%b exp pc=%h pend=1", bus.pc_out,
               bus.redir_pending, 32'h0040_0100);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (bus.pc_out !== 32'h0040_0200) begin
      failures++; $display("FAIL ovw_apply got=%h exp=%h", bus.pc_out, 32'h0040_0200);
    end
    step();
    checks++;
    if (bus.pc_out !== 32'h0040_0204) begin
      failures++; $display("FAIL ovw_next got=%h exp=%h", bus.pc_out, 32'h0040_0204);
    end
  endtask

  task automatic test_exception();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0040);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0080);
    step();
    checks++;
    if (bus.pc_out !== 32'h0040_0040 || bus.redir_pending !== 1'b1) begin
      failures++;
      $display("FAIL exc_setup got pc=%h pend=%b exp pc=%h pend=1", bus.pc_out,
               bus.redir_pending, 32'h0040_0040);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0300);
    step();
    checks++;
    if (bus.pc_out !== 32'h0040_0004 || bus.epc_out !== 32'h0040_0040 ||
        bus.redir_pending !== 1'b0) begin
      failures++;
      $display("FAIL exc_take got pc=%h epc=%h pend=%b exp pc=%h epc=%h pend=0",
               bus.pc_out, bus.epc_out, bus.redir_pending, 32'h0040_0004, 32'h0040_0040);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (bus.pc_out !== 32'h0040_0008) begin
      failures++; $display("FAIL exc_resume got=%h exp=%h", bus.pc_out, 32'h0040_0008);
    end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0102);
    step();
    checks++;
    if (bus.pc_out !== 32'h0040_0100 || bus.addr_err !== 1'b1) begin
      failures++;
      $display("FAIL mis_direct got pc=%h err=%b exp pc=%h err=1", bus.pc_out,
               bus.addr_err, 32'h0040_0100);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (bus.addr_err !== 1'b0 || bus.pc_out !== 32'h0040_0104) begin
      failures++;
      $display("FAIL mis_pulse got pc=%h err=%b exp pc=%h err=0", bus.pc_out,
               bus.addr_err, 32'h0040_0104);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0203);
    step();
    checks++;
    if (bus.addr_err !== 1'b1 || bus.redir_pending !== 1'b1) begin
      failures++;
      $display("FAIL mis_buf got err=%b pend=%b exp 1/1", bus.addr_err, bus.redir_pending);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (bus.addr_err !== 1'b0) begin
      failures++; $display("FAIL mis_buf_pulse got=%b exp=0", bus.addr_err);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (bus.pc_out !== 32'h0040_0200) begin
      failures++; $display("FAIL mis_buf_apply got=%h exp=%h", bus.pc_out, 32'h0040_0200);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0300);
    step();
    checks++;
    if (bus.addr_err !== 1'b0 || bus.pc_out !== 32'h0040_0300) begin
      failures++;
      $display("FAIL aligned_noerr got pc=%h err=%b exp pc=%h err=0", bus.pc_out,
               bus.addr_err, 32'h0040_0300);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0500);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0600);
    step();
    checks++;
    if (bus.pc_out !== 32'h0040_0300 || bus.redir_pending !== 1'b1) begin
      failures++;
      $display("FAIL hold_pend got pc=%h pend=%b exp pc=%h pend=1", bus.pc_out,
               bus.redir_pending, 32'h0040_0300);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    checks++;
    if (bus.pc_out !== 32'h0040_0300 || bus.epc_out !== 32'h0040_0040) begin
      failures++;
      $display("FAIL hold_exc got pc=%h epc=%h exp pc=%h epc=%h", bus.pc_out,
               bus.epc_out, 32'h0040_0300, 32'h0040_0040);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (bus.pc_out !== 32'h0040_0500 || bus.redir_pending !== 1'b0) begin
      failures++;
      $display("FAIL hold_release got pc=%h pend=%b exp pc=%h pend=0", bus.pc_out,
               bus.redir_pending, 32'h0040_0500);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    checks++;
    if (bus.pc_out !== 32'hFFFF_FFFC || bus.pc_plus !== 32'h0) begin
      failures++;
      $display("FAIL wrap_setup got pc=%h plus=%h exp pc=%h plus=0", bus.pc_out,
               bus.pc_plus, 32'hFFFF_FFFC);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (bus.pc_out !== 32'h0) begin
      failures++; $display("FAIL wrap got=%h exp=%h", bus.pc_out, 32'h0);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0700);
    step();
    checks++;
    if (bus.redir_pending !== 1'b1) begin
      failures++; $display("FAIL areset_setup got pend=%b exp=1", bus.redir_pending);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.pc_out !== 32'h0040_0000 || bus.redir_pending !== 1'b0 ||
        bus.epc_out !== 32'h0) begin
      failures++;
      $display("FAIL areset got pc=%h pend=%b epc=%h exp pc=%h pend=0 epc=0",
               bus.pc_out, bus.redir_pending, bus.epc_out, 32'h0040_0000);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    step();
    checks++;
    if (bus.pc_out !== 32'h0040_0004) begin
      failures++; $display("FAIL areset_resume got=%h exp=%h", bus.pc_out, 32'h0040_0004);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_overwrite();
    test_exception();
    test_misaligned();
    test_hold();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
